// File: rtl/cfg_lmmi_pkg.sv
// Shared types and constants for the LMMI configuration-port arbiter family.
// The CRE widths are here so a CRE-port variant can reuse the same arbiter.
package cfg_lmmi_pkg;

    localparam int CFG_OFFSET_W = 8;
    localparam int CFG_DATA_W   = 8;
    localparam int CRE_OFFSET_W = 18;
    localparam int CRE_DATA_W   = 32;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_FIXED_PRIO  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

    // Winner id: 1'b0 = m0, 1'b1 = m1. The round-robin loser is the last owner.
    function automatic logic pick_owner(input int mode, input logic [1:0] req, input logic last_grant);
        logic winner;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = (mode == ARB_FIXED_PRIO) ? 1'b0 : ~last_grant;
            default: winner = 1'b0;
        endcase
        return winner;
    endfunction

endpackage

// File: rtl/cfg_lmmi_arbiter_if.sv
// One LMMI link: the master drives request/command, the slave returns ready and read data.
interface cfg_lmmi_arbiter_if #(
    parameter int OFFSET_W = 8,
    parameter int DATA_W   = 8
);
    logic                request;
    logic                wr_rdn;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   wdata;
    logic                ready;
    logic [DATA_W-1:0]   rdata;
    logic                rdata_valid;

    modport master (
        output request, wr_rdn, offset, wdata,
        input  ready, rdata, rdata_valid
    );

    modport slave (
        input  request, wr_rdn, offset, wdata,
        output ready, rdata, rdata_valid
    );
endinterface

// File: rtl/lmmi_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches LIMIT-1. The counter saturates at LIMIT.
module lmmi_phase_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         expired_q;

    // Next count: clear wins over enable, and the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != W'(LIMIT))) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register and registered expiry flag.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == W'(LIMIT - 1));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/cfg_lmmi_arbiter.sv
// Two-requester arbiter for the configuration LMMI slave port: m0 = host, m1 = boot FSM.
// Whole transactions are serialised and every slave phase is bounded by a timeout.
module cfg_lmmi_arbiter
    import cfg_lmmi_pkg::*;
#(
    parameter int                OFFSET_W     = CFG_OFFSET_W,
    parameter int                DATA_W       = CFG_DATA_W,
    parameter int                ARB_MODE     = ARB_ROUND_ROBIN,
    parameter int                TIMEOUT_CYC  = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = {DATA_W{1'b1}}
) (
    input  logic                      lmmi_clk_i,
    input  logic                      lmmi_resetn_i,
    cfg_lmmi_arbiter_if.slave         m0_if,
    cfg_lmmi_arbiter_if.slave         m1_if,
    cfg_lmmi_arbiter_if.master        s_if,
    output logic                      m0_timeout_o,
    output logic                      m1_timeout_o,
    output logic                      busy_o
);

    arb_state_e          state_q;
    logic                owner_q;
    logic                last_grant_q;
    logic                s_request_q;
    logic                s_wr_rdn_q;
    logic [OFFSET_W-1:0] s_offset_q;
    logic [DATA_W-1:0]   s_wdata_q;
    logic [DATA_W-1:0]   rdata_q [2];
    logic [1:0]          rdata_valid_q;

    logic [1:0]          req_s;
    logic                pick_s;
    logic                pick_wr_s;
    logic [OFFSET_W-1:0] pick_offset_s;
    logic [DATA_W-1:0]   pick_wdata_s;
    logic                in_grant_s;
    logic                in_rdwait_s;
    logic                expired_s;
    logic                abort_s;
    logic                abort_rd_s;
    logic                done_s;
    logic                timer_clear_s;
    logic                timer_en_s;

    assign req_s  = {m1_if.request, m0_if.request};
    assign pick_s = pick_owner(ARB_MODE, req_s, last_grant_q);

    // Command fields of whichever requester wins this IDLE cycle.
    always_comb begin
        pick_wr_s     = m0_if.wr_rdn;
        pick_offset_s = m0_if.offset;
        pick_wdata_s  = m0_if.wdata;
        if (pick_s) begin
            pick_wr_s     = m1_if.wr_rdn;
            pick_offset_s = m1_if.offset;
            pick_wdata_s  = m1_if.wdata;
        end else begin
            pick_wr_s     = m0_if.wr_rdn;
            pick_offset_s = m0_if.offset;
            pick_wdata_s  = m0_if.wdata;
        end
    end

    assign in_grant_s  = (state_q == GRANT);
    assign in_rdwait_s = (state_q == RDWAIT);

    // A timeout only counts when the awaited slave event is not arriving in the same cycle.
    assign abort_s    = expired_s & ((in_grant_s & ~s_if.ready) | (in_rdwait_s & ~s_if.rdata_valid));
    assign abort_rd_s = abort_s & ~s_wr_rdn_q;
    assign done_s     = in_grant_s & (s_if.ready | expired_s);

    assign timer_clear_s = (state_q == IDLE) | (in_grant_s & s_if.ready);
    assign timer_en_s    = in_grant_s | in_rdwait_s;

    lmmi_phase_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk_i     (lmmi_clk_i),
        .resetn_i  (lmmi_resetn_i),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_en_s),
        .expired_o (expired_s)
    );

    // Arbitration FSM with the latched slave-side command and per-requester read data.
    always_ff @(posedge lmmi_clk_i) begin
        if (!lmmi_resetn_i) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            s_request_q   <= 1'b0;
            s_wr_rdn_q    <= 1'b0;
            s_offset_q    <= '0;
            s_wdata_q     <= '0;
            rdata_q[0]    <= '0;
            rdata_q[1]    <= '0;
            rdata_valid_q <= 2'b00;
        end else begin
            rdata_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req_s) begin
                        owner_q      <= pick_s;
                        last_grant_q <= pick_s;
                        s_wr_rdn_q   <= pick_wr_s;
                        s_offset_q   <= pick_offset_s;
                        s_wdata_q    <= pick_wdata_s;
                        s_request_q  <= 1'b1;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (s_if.ready) begin
                        s_request_q <= 1'b0;
                        if (s_wr_rdn_q) begin
                            state_q <= IDLE;
                        end else if (s_if.rdata_valid) begin
                            rdata_q[owner_q]       <= s_if.rdata;
                            rdata_valid_q[owner_q] <= 1'b1;
                            state_q                <= IDLE;
                        end else begin
                            state_q <= RDWAIT;
                        end
                    end else if (expired_s) begin
                        s_request_q <= 1'b0;
                        if (!s_wr_rdn_q) begin
                            rdata_q[owner_q] <= TIMEOUT_DATA;
                        end
                        state_q <= IDLE;
                    end
                end
                RDWAIT: begin
                    if (s_if.rdata_valid) begin
                        rdata_q[owner_q]       <= s_if.rdata;
                        rdata_valid_q[owner_q] <= 1'b1;
                        state_q                <= IDLE;
                    end else if (expired_s) begin
                        rdata_q[owner_q] <= TIMEOUT_DATA;
                        state_q          <= IDLE;
                    end
                end
                default: begin
                    s_request_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign s_if.request = s_request_q;
    assign s_if.wr_rdn  = s_wr_rdn_q;
    assign s_if.offset  = s_offset_q;
    assign s_if.wdata   = s_wdata_q;

    // Ready and abort strobes appear in the cycle that ends the phase; slave data is registered.
    assign m0_if.ready       = done_s & ~owner_q;
    assign m1_if.ready       = done_s &  owner_q;
    assign m0_timeout_o      = abort_s & ~owner_q;
    assign m1_timeout_o      = abort_s &  owner_q;
    assign m0_if.rdata_valid = rdata_valid_q[0] | (abort_rd_s & ~owner_q);
    assign m1_if.rdata_valid = rdata_valid_q[1] | (abort_rd_s &  owner_q);
    assign m0_if.rdata       = (abort_rd_s & ~owner_q) ? TIMEOUT_DATA : rdata_q[0];
    assign m1_if.rdata       = (abort_rd_s &  owner_q) ? TIMEOUT_DATA : rdata_q[1];
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_cfg_lmmi_arbiter.sv
// Directed bench for cfg_lmmi_arbiter: a transaction table against a round-robin
// instance (TIMEOUT_CYC=8) plus arbitration-order and reset sequences.
module tb_cfg_lmmi_arbiter;

    localparam int NV = 99;

    typedef struct {
        logic       who;
        logic       wr;
        logic [7:0] off;
        logic [7:0] wd;
        int         rdy;
        int         vld;
        logic [7:0] sd;
        logic       drop;
        int         e_rdy;
        int         e_to;
        int         e_rv;
        logic [7:0] e_rd;
        int         e_idle;
    } vec_t;

    logic clk;
    logic rstn;
    logic to0a, to1a, busya, to0b, to1b, busyb;
    int   n_tests;
    int   n_fail;

    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) m0a ();
    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) m1a ();
    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) sa ();
    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) m0b ();
    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) m1b ();
    cfg_lmmi_arbiter_if #(.OFFSET_W(8), .DATA_W(8)) sb ();

    cfg_lmmi_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(8), .TIMEOUT_DATA(8'hFF)) dut_rr (
        .lmmi_clk_i(clk), .lmmi_resetn_i(rstn),
        .m0_if(m0a), .m1_if(m1a), .s_if(sa),
        .m0_timeout_o(to0a), .m1_timeout_o(to1a), .busy_o(busya)
    );

    cfg_lmmi_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(8), .TIMEOUT_DATA(8'hFF)) dut_fp (
        .lmmi_clk_i(clk), .lmmi_resetn_i(rstn),
        .m0_if(m0b), .m1_if(m1b), .s_if(sb),
        .m0_timeout_o(to0b), .m1_timeout_o(to1b), .busy_o(busyb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic who, input logic r, input logic wr, input logic [7:0] off, input logic [7:0] wd);
        if (who) begin
            m1a.request = r; m1a.wr_rdn = wr; m1a.offset = off; m1a.wdata = wd;
        end else begin
            m0a.request = r; m0a.wr_rdn = wr; m0a.offset = off; m0a.wdata = wd;
        end
    endtask

    // Apply one table transaction on dut_rr with a reactive slave and check its timing.
    task automatic run_txn(input int idx, input vec_t v);
        int gcnt, rdy_at, f_rdy, n_rdy, f_to, f_rv, f_idle;
        logic [7:0] rv_data, off1, wd1;
        logic wr1, req1, other_hi;
        gcnt = 0; rdy_at = 0; f_rdy = 0; n_rdy = 0; f_to = 0; f_rv = 0; f_idle = 0;
        rv_data = 8'h00; off1 = 8'h00; wd1 = 8'h00; wr1 = 1'b0; req1 = 1'b0; other_hi = 1'b0;
        set_req(v.who, 1'b1, v.wr, v.off, v.wd);
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            sa.ready = 1'b0; sa.rdata_valid = 1'b0;
            if (sa.request) begin
                gcnt++;
                if (gcnt == v.rdy) begin
                    sa.ready = 1'b1; rdy_at = n;
                    if (v.vld == 0) begin sa.rdata_valid = 1'b1; sa.rdata = v.sd; end
                end
            end
            if (rdy_at > 0 && v.vld > 0 && n == rdy_at + v.vld) begin
                sa.rdata_valid = 1'b1; sa.rdata = v.sd;
            end
            if (n == 1) begin off1 = sa.offset; wd1 = sa.wdata; wr1 = sa.wr_rdn; req1 = sa.request; end
            #1;
            if (v.who ? m1a.ready : m0a.ready) begin
                n_rdy++;
                if (f_rdy == 0) f_rdy = n;
                set_req(v.who, 1'b0, v.wr, v.off, v.wd);
            end
            if (v.drop && n == 1) set_req(v.who, 1'b0, v.wr, v.off, v.wd);
            if ((v.who ? to1a : to0a) && f_to == 0) f_to = n;
            if ((v.who ? m1a.rdata_valid : m0a.rdata_valid) && f_rv == 0) begin
                f_rv = n; rv_data = v.who ? m1a.rdata : m0a.rdata;
            end
            if (!busya && f_idle == 0) f_idle = n;
            if (v.who ? (m0a.ready | m0a.rdata_valid | to0a) : (m1a.ready | m1a.rdata_valid | to1a))
                other_hi = 1'b1;
        end
        sa.ready = 1'b0; sa.rdata_valid = 1'b0;
        chk($sformatf("v%0d s_request", idx), {31'd0, req1}, 32'd1);
        chk($sformatf("v%0d s_offset", idx), {24'd0, off1}, {24'd0, v.off});
        chk($sformatf("v%0d s_wdata", idx), {24'd0, wd1}, {24'd0, v.wd});
        chk($sformatf("v%0d s_wr_rdn", idx), {31'd0, wr1}, {31'd0, v.wr});
        chk($sformatf("v%0d ready_cycle", idx), f_rdy, v.e_rdy);
        chk($sformatf("v%0d ready_count", idx), n_rdy, 32'd1);
        chk($sformatf("v%0d timeout_cycle", idx), f_to, v.e_to);
        chk($sformatf("v%0d rvalid_cycle", idx), f_rv, v.e_rv);
        chk($sformatf("v%0d rdata", idx), {24'd0, rv_data}, {24'd0, v.e_rd});
        chk($sformatf("v%0d busy_low_cycle", idx), f_idle, v.e_idle);
        chk($sformatf("v%0d other_silent", idx), {31'd0, other_hi}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [9];
        vec_t fresh;
        logic [7:0] ga [4];
        logic [7:0] gb [4];
        logic [7:0] exp_a [4];
        logic [7:0] first_m1b;
        int na, nb;
        logic b_bad;

        n_tests = 0; n_fail = 0;
        tv[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 3,  NV, 8'h00, 1'b0, 3, 0, 0, 8'h00, 4};
        tv[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1,  4,  8'h5C, 1'b0, 1, 0, 6, 8'h5C, 6};
        tv[2] = '{1'b0, 1'b1, 8'h30, 8'h11, NV, NV, 8'h00, 1'b0, 8, 8, 0, 8'h00, 9};
        tv[3] = '{1'b1, 1'b0, 8'h31, 8'h00, NV, NV, 8'h00, 1'b0, 8, 8, 8, 8'hFF, 9};
        tv[4] = '{1'b0, 1'b0, 8'h40, 8'h00, 2,  0,  8'h3E, 1'b0, 2, 0, 3, 8'h3E, 3};
        tv[5] = '{1'b1, 1'b0, 8'h50, 8'h00, 1,  NV, 8'h00, 1'b0, 1, 9, 9, 8'hFF, 10};
        tv[6] = '{1'b0, 1'b0, 8'h60, 8'h00, 1,  1,  8'h81, 1'b0, 1, 0, 3, 8'h81, 3};
        tv[7] = '{1'b1, 1'b1, 8'h70, 8'hC3, 7,  NV, 8'h00, 1'b0, 7, 0, 0, 8'h00, 8};
        tv[8] = '{1'b0, 1'b1, 8'h33, 8'h44, 3,  NV, 8'h00, 1'b1, 3, 0, 0, 8'h00, 4};
        fresh = '{1'b1, 1'b0, 8'h44, 8'h00, 2, 2, 8'hA7, 1'b0, 2, 0, 5, 8'hA7, 5};
        exp_a[0] = 8'h01; exp_a[1] = 8'h02; exp_a[2] = 8'h01; exp_a[3] = 8'h02;

        rstn = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        m0b.request = 1'b0; m0b.wr_rdn = 1'b0; m0b.offset = 8'h00; m0b.wdata = 8'h00;
        m1b.request = 1'b0; m1b.wr_rdn = 1'b0; m1b.offset = 8'h00; m1b.wdata = 8'h00;
        sa.ready = 1'b0; sa.rdata_valid = 1'b0; sa.rdata = 8'h00;
        sb.ready = 1'b0; sb.rdata_valid = 1'b0; sb.rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busya}, 32'd0);
        chk("reset s_request", {31'd0, sa.request}, 32'd0);
        chk("reset s_offset", {24'd0, sa.offset}, 32'd0);
        chk("reset m0 outputs", {29'd0, m0a.ready, m0a.rdata_valid, to0a}, 32'd0);
        chk("reset m1 rdata", {24'd0, m1a.rdata}, 32'd0);
        rstn = 1'b1;

        // Both requesters issue continuous writes from reset on both instances.
        set_req(1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'h02, 8'h00);
        m0b.request = 1'b1; m0b.wr_rdn = 1'b1; m0b.offset = 8'h01;
        m1b.request = 1'b1; m1b.wr_rdn = 1'b1; m1b.offset = 8'h02;
        na = 0; nb = 0; b_bad = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            sa.ready = sa.request; sb.ready = sb.request;
            if (sa.request && na < 4) begin ga[na] = sa.offset; na++; end
            if (sb.request && nb < 4) begin gb[nb] = sb.offset; nb++; end
            #1;
            if (m1b.ready | to0b | to1b | m0b.rdata_valid | m1b.rdata_valid) b_bad = 1'b1;
        end
        set_req(1'b0, 1'b0, 1'b1, 8'h01, 8'h00);
        set_req(1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
        m0b.request = 1'b0;
        sa.ready = 1'b0;
        chk("rr grant count", na, 32'd4);
        chk("fp grant count", nb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr grant %0d", i), {24'd0, ga[i]}, {24'd0, exp_a[i]});
            chk($sformatf("fp grant %0d", i), {24'd0, gb[i]}, 32'h01);
        end
        chk("fp m1 starved", {31'd0, b_bad}, 32'd0);
        first_m1b = 8'h00;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            sb.ready = sb.request;
            if (sb.request && first_m1b == 8'h00) first_m1b = sb.offset;
        end
        m1b.request = 1'b0; sb.ready = 1'b0;
        chk("fp m1 served after m0 idle", {24'd0, first_m1b}, 32'h02);
        repeat (3) @(posedge clk);

        // Stray slave strobes with no transaction in flight must be ignored.
        #1;
        sa.ready = 1'b1; sa.rdata_valid = 1'b1; sa.rdata = 8'h77;
        b_bad = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            if (busya | m0a.ready | m0a.rdata_valid | m1a.ready | m1a.rdata_valid | sa.request) b_bad = 1'b1;
        end
        sa.ready = 1'b0; sa.rdata_valid = 1'b0;
        chk("idle stray strobes", {31'd0, b_bad}, 32'd0);
        chk("idle m0 rdata held", {24'd0, m0a.rdata}, 32'd0);

        for (int i = 0; i < 9; i++) run_txn(i, tv[i]);

        // Reset during RDWAIT of an m1 read.
        set_req(1'b1, 1'b1, 1'b0, 8'h44, 8'h00);
        @(posedge clk); #1;
        sa.ready = sa.request;
        #1;
        set_req(1'b1, 1'b0, 1'b0, 8'h44, 8'h00);
        @(posedge clk); #1;
        sa.ready = 1'b0;
        chk("rdwait busy before reset", {31'd0, busya}, 32'd1);
        chk("rdwait m1 rdata held", {24'd0, m1a.rdata}, 32'hFF);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        sa.rdata_valid = 1'b1; sa.rdata = 8'h99;
        #1;
        chk("post-reset busy", {31'd0, busya}, 32'd0);
        chk("post-reset s_request", {31'd0, sa.request}, 32'd0);
        chk("post-reset m1 flags", {29'd0, m1a.ready, m1a.rdata_valid, to1a}, 32'd0);
        chk("post-reset m1 rdata", {24'd0, m1a.rdata}, 32'd0);
        @(posedge clk); #1;
        chk("post-reset stray valid", {31'd0, m1a.rdata_valid}, 32'd0);
        sa.rdata_valid = 1'b0;
        @(posedge clk); #1;
        run_txn(9, fresh);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
